// File: rtl/axi_llc_refill_unit.sv
// -----------------------------------------------------------------------------
// axi_llc_refill_unit
//
// Sits after the miss buffer. For a refill descriptor it gathers the R beats of
// one cache line (the AR is already in flight) and writes every beat into the
// selected data way. Once the line is complete, or straight away for a
// non-refill descriptor, the descriptor goes on to the response stage.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   desc_*_i / desc_ready_o   incoming descriptor from the miss buffer
//   r_*_i / r_ready_o         AXI R channel beats of the refilled line
//   way_req_*                 write requests into the data way (one per beat)
//   desc_*_o / desc_ready_i   outgoing descriptor to the response stage
//   desc_err_o                some beat of the line came back with resp[1] set
//   protocol_err_o            one-cycle pulse when r_last disagrees with the
//                             beat counter
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high. Once a valid is raised, it and its payload
// stay put until that transfer. A valid never waits for its ready. The R beat
// and the way write in FILL are one transfer, because R ready is the way ready
// passed straight through and way valid is R valid passed straight through.
// -----------------------------------------------------------------------------
module axi_llc_refill_unit #(
    parameter int WayIdxWidth = 3,
    parameter int IndexWidth  = 8,
    parameter int Beats       = 8,
    parameter int DataWidth   = 64,
    parameter int UserWidth   = 16,
    localparam int OffW       = $clog2(Beats)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // descriptor in
    input  logic                   desc_valid_i,
    output logic                   desc_ready_o,
    input  logic                   desc_refill_i,
    input  logic [WayIdxWidth-1:0] desc_way_i,
    input  logic [IndexWidth-1:0]  desc_index_i,
    input  logic [UserWidth-1:0]   desc_user_i,
    // R channel
    input  logic [DataWidth-1:0]   r_data_i,
    input  logic [1:0]             r_resp_i,
    input  logic                   r_last_i,
    input  logic                   r_valid_i,
    output logic                   r_ready_o,
    // data way write
    output logic                   way_req_valid_o,
    input  logic                   way_req_ready_i,
    output logic [WayIdxWidth-1:0] way_req_way_o,
    output logic [IndexWidth-1:0]  way_req_index_o,
    output logic [OffW-1:0]        way_req_offset_o,
    output logic [DataWidth-1:0]   way_req_data_o,
    // descriptor out
    output logic                   desc_valid_o,
    input  logic                   desc_ready_i,
    output logic [WayIdxWidth-1:0] desc_way_o,
    output logic [IndexWidth-1:0]  desc_index_o,
    output logic [UserWidth-1:0]   desc_user_o,
    output logic                   desc_err_o,
    output logic                   protocol_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam logic [OffW-1:0] LastOff = OffW'(Beats - 1);

    state_e                 state_q, state_d;
    logic [OffW-1:0]        cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   perr_q, perr_d;
    logic [WayIdxWidth-1:0] way_q, way_d;
    logic [IndexWidth-1:0]  index_q, index_d;
    logic [UserWidth-1:0]   user_q, user_d;

    logic beat_xfer;
    logic last_beat;

    // Only resp[1] matters: SLVERR and DECERR both flag the line.
    logic unused_resp;
    assign unused_resp = r_resp_i[0];

    assign beat_xfer = r_valid_i & way_req_ready_i;
    assign last_beat = (cnt_q == LastOff);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        perr_d          = 1'b0;
        way_d           = way_q;
        index_d         = index_q;
        user_d          = user_q;
        desc_ready_o    = 1'b0;
        r_ready_o       = 1'b0;
        way_req_valid_o = 1'b0;
        way_req_data_o  = '0;
        desc_valid_o    = 1'b0;

        case (state_q)
            IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    way_d   = desc_way_i;
                    index_d = desc_index_i;
                    user_d  = desc_user_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = desc_refill_i ? FILL : OUT;
                end
            end
            FILL: begin
                way_req_valid_o = r_valid_i;
                r_ready_o       = way_req_ready_i;
                way_req_data_o  = r_data_i;
                if (beat_xfer) begin
                    // The beat counter decides when the line ends; r_last is
                    // only compared against it and reported on a mismatch.
                    cnt_d  = cnt_q + OffW'(1);
                    err_d  = err_q | r_resp_i[1];
                    perr_d = (r_last_i != last_beat);
                    if (last_beat) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                desc_valid_o = 1'b1;
                if (desc_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            perr_q  <= 1'b0;
            way_q   <= '0;
            index_q <= '0;
            user_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            perr_q  <= perr_d;
            way_q   <= way_d;
            index_q <= index_d;
            user_q  <= user_d;
        end
    end

    assign way_req_way_o    = way_q;
    assign way_req_index_o  = index_q;
    assign way_req_offset_o = cnt_q;

    assign desc_way_o       = way_q;
    assign desc_index_o     = index_q;
    assign desc_user_o      = user_q;
    assign desc_err_o       = err_q;
    assign protocol_err_o   = perr_q;

endmodule

// File: doc/axi_llc_refill_unit.md
Name: axi_llc_refill_unit

Overview:
- Downstream neighbour of the eviction pipeline.
- Consumes descriptors leaving the miss buffer, after the AR for the line has already been issued.
- For refill descriptors, collects the R beats of one cache line and writes each beat into the selected data way.
- Forwards the descriptor to the read/write response stage when the line is complete. Non-refill descriptors pass through without touching R.

Parameters:
- WayIdxWidth, 3, width of the way index.
- IndexWidth, 8, width of the set index.
- Beats, 8, R beats per cache line; power of two, at least 2.
- DataWidth, 64, R data and way write data width.
- UserWidth, 16, opaque descriptor payload carried through unchanged.
- OffW, $clog2(Beats), derived; not overridable.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- desc_valid_i  in  1  input descriptor valid.
- desc_ready_o  out  1  unit accepts a descriptor.
- desc_refill_i  in  1  descriptor requires a line refill.
- desc_way_i  in  WayIdxWidth  target way.
- desc_index_i  in  IndexWidth  target set.
- desc_user_i  in  UserWidth  pass-through payload.
- r_data_i  in  DataWidth  R beat data.
- r_resp_i  in  2  R beat response.
- r_last_i  in  1  R beat last flag.
- r_valid_i  in  1  R beat valid.
- r_ready_o  out  1  R beat ready.
- way_req_valid_o  out  1  way write request valid.
- way_req_ready_i  in  1  way accepts the request.
- way_req_way_o  out  WayIdxWidth  way to write.
- way_req_index_o  out  IndexWidth  set to write.
- way_req_offset_o  out  OffW  beat offset within the line.
- way_req_data_o  out  DataWidth  write data.
- desc_valid_o  out  1  output descriptor valid.
- desc_ready_i  in  1  downstream accepts the descriptor.
- desc_way_o  out  WayIdxWidth  registered way.
- desc_index_o  out  IndexWidth  registered set.
- desc_user_o  out  UserWidth  registered payload.
- desc_err_o  out  1  at least one R beat had resp[1] set.
- protocol_err_o  out  1  one-cycle pulse on an r_last mismatch.

Behaviour:
- FSM states:
  - IDLE: desc_ready_o=1; all other valid/ready outputs are 0.
  - FILL.
  - OUT.
- Reset (rst_i high at a clock edge):
  - State goes to IDLE, beat counter to 0, err flag to 0.
  - Registered desc fields clear to 0; protocol_err_o goes to 0.
  - After reset: desc_ready_o=1 and all other outputs 0.
  - Reset during FILL or OUT abandons the line. Remaining R beats are not consumed and are not replayed.
- IDLE, on desc_valid_i & desc_ready_o:
  - Register way, index and user; clear err and counter.
  - desc_refill_i=1: go to FILL.
  - desc_refill_i=0: go to OUT; no R or way traffic.
- FILL, zero-latency combinational pass-through:
  - way_req_valid_o = r_valid_i.
  - r_ready_o = way_req_ready_i.
  - way_req_data_o = r_data_i.
  - way_req_offset_o = counter; way/index come from the registers.
- FILL, on a beat transfer (r_valid_i & way_req_ready_i):
  - Counter increments modulo Beats.
  - err |= r_resp_i[1].
  - protocol_err_o is pulsed the next cycle if r_last_i != (counter == Beats-1).
  - The counter is authoritative. An early r_last_i does not end the fill; a missing r_last_i on the final beat still ends it.
- FILL exit: a transfer with counter == Beats-1 moves to OUT; the counter wraps to 0.
- FILL, outside a transfer: r_ready_o and way_req_valid_o never assert in any other state. way_req_valid_o never asserts without r_valid_i.
- OUT:
  - desc_valid_o=1; desc_* and desc_err_o are stable until desc_ready_i.
  - On handshake go to IDLE. There is a one-cycle bubble before the next descriptor is accepted.
- desc_ready_o is high only in IDLE; there is no combinational path from desc_ready_i to desc_ready_o.
- Throughput: Beats cycles per refill line under continuous R and way ready, plus 1 cycle OUT and 1 cycle IDLE.

Test Plan:
- Refill desc (way=2, index=0x15), 8 R beats data=0..7 back-to-back, resp OKAY, last on beat 7 -> way writes offset 0..7 with data 0..7 to way 2 / set 0x15; desc_valid_o in the cycle after beat 7; desc_err_o=0.
- Non-refill desc -> r_ready_o stays 0 and no way request; desc_valid_o one cycle after acceptance with the same user value.
- way_req_ready_i toggled 1/0 each cycle during a fill -> r_ready_o mirrors it; 8 writes complete in 16 cycles; offsets in order with no duplicates.
- Beat 3 with resp=SLVERR and r_last_i on beat 5 -> desc_err_o=1; protocol_err_o pulses after beats 5 and 7; fill still ends after beat 7.
- Hold desc_ready_i=0 for 10 cycles in OUT -> desc_valid_o and payload stable; desc_ready_o=0; a new desc_valid_i is not accepted.
- Assert rst_i after beat 4 -> next cycle: IDLE, desc_ready_o=1, r_ready_o=0, desc_valid_o=0; a new refill restarts at offset 0.
